bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Multiplexed 7-segment display driver sitting directly downstream of the N-digit BCD counter.
- Consumes the packed BCD bus and per-digit decimal points.
- Time-multiplexes one digit at a time onto shared segment lines plus one-hot anode enables.
- Snapshots the whole bus once per frame so the display never tears while the counter ripples.

Parameters:
- N, 3, number of BCD digits scanned (>=1).
- REFRESH_DIV, 50000, clk cycles each digit is displayed (>=2).
- GUARD_CYCLES, 8, blanking cycles between digits; used only with SCAN_GUARD_EN (>=1).
- IW, CLOG2(N) with minimum 1, digit index width (derived; ceiling log2, not floor).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bcd_in  in  N*4  packed digits, digit i at [(i+1)*4-1:i*4], digit 0 least significant.
- dp_in  in  N  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  N  anode enables, active-low one-hot, registered.
- digit_idx  out  IW  index of the digit currently driven on an/seg.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (rst=0, asynchronous):
  - div_cnt=0, idx=0, snapshot=0, dp_snap=0.
  - an=all 1, seg=7'h7F, dp=1, digit_idx=0, frame_start=0.
- Prescaler:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick = (div_cnt==REFRESH_DIV-1).
- Index:
  - On tick, idx <= (idx==N-1) ? 0 : idx+1.
- Snapshot:
  - In every cycle with idx==0 and div_cnt==0 (including the first cycle after reset release), snapshot<=bcd_in, dp_snap<=dp_in, and frame_start<=1.
  - In all other cycles frame_start<=0.
  - Changes to bcd_in and dp_in mid-frame are invisible until the next snapshot.
- Output registers (every cycle, one-cycle latency from idx):
  - an <= ~(1<<idx).
  - seg <= decode(snapshot digit idx).
  - dp <= ~dp_snap[idx].
  - digit_idx <= idx.
- First lit digit: digit 0, visible in the 2nd cycle after reset release.
- Decode (active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex).
  - Nibbles 10..15: dash 7'h3F.
- Leading-zero blanking (blank_lz=1):
  - Digit i>0 is blanked (seg=7'h7F) when snapshot digits i..N-1 are all 0.
  - Digit 0 is never blanked.
  - The anode is still asserted and dp still follows dp_snap, so duty cycle stays constant.
  - blank_lz is sampled live, not snapshotted.
- Each digit is lit exactly REFRESH_DIV cycles; a frame is N*REFRESH_DIV cycles.
- Reset mid-scan forces all outputs to reset values immediately and restarts at digit 0.

Optional Feature:
- Macro: SCAN_GUARD_EN.
- Defined:
  - Two-state FSM, SHOW and GUARD.
  - SHOW behaves as above. On tick: SHOW->GUARD, guard counter cleared, div_cnt held at 0.
  - GUARD drives an=all 1 and seg=7'h7F for GUARD_CYCLES cycles, then advances idx and returns to SHOW.
  - Frame = N*(REFRESH_DIV+GUARD_CYCLES).
  - The snapshot rule additionally requires state==SHOW.
  - Reset state is SHOW.
- Undefined:
  - No FSM and no guard counter; idx advances directly on tick.
  - GUARD_CYCLES is ignored.

Decomposition:
- Package display_pkg:
  - Segment constants SEG_0..SEG_9, SEG_OFF=7'h7F, SEG_DASH=7'h3F.
  - Scan state enum {SHOW, GUARD}.
  - CLOG2 function.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-bit active-low decoder, one instance driven by the muxed snapshot digit.

Test Plan (N=3, REFRESH_DIV=4, GUARD_CYCLES=2 unless noted):
1. Reset
   - Stimulus: assert rst=0 for 3 cycles with random bcd_in.
   - Required: an=3'b111, seg=7'h7F, dp=1, digit_idx=0, frame_start=0.
2. Basic scan
   - Stimulus: bcd_in=12'h925, dp_in=3'b010, release reset.
   - Required: frame_start in cycle 1.
   - Required: an=110/seg=12 for 4 cycles, then an=101/seg=24/dp=0 for 4 cycles, then an=011/seg=10 for 4 cycles.
   - Required: then back to digit 0 with frame_start.
3. Snapshot isolation
   - Stimulus: change bcd_in to 12'h111 while digit_idx=1.
   - Required: digits 1 and 2 still show 2 and 9; next frame shows 79 on all digits.
4. Leading-zero blanking
   - Stimulus: blank_lz=1 with bcd_in=12'h007.
   - Required: digits 2 and 1 show seg=7F with anodes still active; digit 0 shows 78.
   - Stimulus: bcd_in=12'h000.
   - Required: digit 0 shows 40.
5. Invalid nibble
   - Stimulus: bcd_in=12'h0B3.
   - Required: digit 1 shows 3F.
   - Stimulus: mid-scan async reset (rst low between clock edges).
   - Required: outputs return to reset values without a clock edge.
6. Guard (SCAN_GUARD_EN defined)
   - Required: 2 cycles of an=111/seg=7F between every digit; frame length 18 cycles; frame_start period 18.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
//
// Contents:
//   SEG_0..SEG_9  active-low segment patterns {g,f,e,d,c,b,a} for the decimal digits
//   SEG_OFF       all segments dark
//   SEG_DASH      middle bar only, shown for nibbles 10..15
//   scan_state_e  scan FSM states (used only when SCAN_GUARD_EN is defined)
//   CLOG2         ceiling log2, never less than 1, for sizing counters and indices
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } scan_state_e;

    // Ceiling log2, clamped to 1 so a single-entry range still gets a 1-bit vector.
    function automatic int CLOG2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
//
// Ports:
//   bcd  in   4  digit value; 0..9 decode normally, 10..15 show a dash
//   seg  out  7  {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment display driver. Scans N BCD digits one at a time onto
// shared segment lines with one-hot active-low anodes. The whole BCD bus is
// snapshotted once per frame so a rippling counter upstream never tears the
// displayed value.
//
// Ports:
//   clk          in   1     system clock, rising edge
//   rst          in   1     asynchronous reset, active low
//   bcd_in       in   N*4   packed digits, digit 0 in [3:0]
//   dp_in        in   N     per-digit decimal point request, 1 = lit
//   blank_lz     in   1     1 = suppress leading zeros (sampled live)
//   seg          out  7     {g,f,e,d,c,b,a}, active low, registered
//   dp           out  1     decimal point, active low, registered
//   an           out  N     anode enables, active-low one-hot, registered
//   digit_idx    out  IW    digit currently shown on an/seg
//   frame_start  out  1     one-cycle pulse when a snapshot is taken
//
// Build option: define SCAN_GUARD_EN to insert GUARD_CYCLES blanking cycles
// between digits (suppresses ghosting on slow anode drivers). Without it the
// scan advances straight from digit to digit and GUARD_CYCLES is unused.
//
// Scan FSM (SCAN_GUARD_EN only):
//   state | meaning
//   SHOW  | current digit lit, prescaler running
//   GUARD | all anodes off, prescaler held at 0, guard counter running
module bcd_display_scan
    import display_pkg::*;
#(
    parameter  int N            = 3,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int GUARD_CYCLES = 8,
    localparam int IW           = CLOG2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*4-1:0]  bcd_in,
    input  logic [N-1:0]    dp_in,
    input  logic            blank_lz,
    output logic [6:0]      seg,
    output logic            dp,
    output logic [N-1:0]    an,
    output logic [IW-1:0]   digit_idx,
    output logic            frame_start
);

    localparam int            DW       = CLOG2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    if (N < 1 || REFRESH_DIV < 2 || GUARD_CYCLES < 1) begin : g_bad_param
        $error("bcd_display_scan: parameter out of range");
    end

    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N*4-1:0] snap_q, snap_d;
    logic [N-1:0]   dp_snap_q, dp_snap_d;
    logic [N-1:0]   an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic [IW-1:0]  digit_idx_q, digit_idx_d;
    logic           frame_start_q, frame_start_d;

    logic           tick;
    logic           in_show;
    logic           take_snap;
    logic [IW-1:0]  next_idx;
    logic [3:0]     cur_digit;
    logic           cur_dp;
    logic           cur_zero_above;
    logic [6:0]     cur_seg;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

`ifdef SCAN_GUARD_EN
    localparam int            GW         = CLOG2(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    scan_state_e    state_q, state_d;
    logic [GW-1:0]  guard_cnt_q, guard_cnt_d;

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        div_cnt_d   = div_cnt_q;
        idx_d       = idx_q;
        case (state_q)
            SHOW: begin
                if (tick) begin
                    state_d     = GUARD;
                    guard_cnt_d = '0;
                    div_cnt_d   = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            GUARD: begin
                div_cnt_d = '0;
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = SHOW;
                    idx_d   = next_idx;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SHOW;
            guard_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign in_show = (state_q == SHOW);
`else
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = tick ? next_idx : idx_q;
    end

    assign in_show = 1'b1;
`endif

    // Snapshot at the very first prescaler cycle of digit 0, so a frame always
    // shows one coherent counter value.
    assign take_snap     = in_show && (idx_q == '0) && (div_cnt_q == '0);
    assign snap_d        = take_snap ? bcd_in : snap_q;
    assign dp_snap_d     = take_snap ? dp_in : dp_snap_q;
    assign frame_start_d = take_snap;

    // Digit mux plus leading-zero detection: a digit counts as a leading zero
    // when it and every more significant snapshot digit are zero.
    always_comb begin
        logic all_zero;
        all_zero       = 1'b1;
        cur_digit      = '0;
        cur_dp         = 1'b0;
        cur_zero_above = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            all_zero = all_zero && (snap_q[i*4 +: 4] == 4'd0);
            if (idx_q == IW'(i)) begin
                cur_digit      = snap_q[i*4 +: 4];
                cur_dp         = dp_snap_q[i];
                cur_zero_above = all_zero;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Blanked leading zeros keep their anode and dp so brightness stays uniform.
    always_comb begin
        an_d        = ~(N'(1) << idx_q);
        seg_d       = (blank_lz && (idx_q != '0) && cur_zero_above) ? SEG_OFF : cur_seg;
        dp_d        = ~cur_dp;
        digit_idx_d = idx_q;
        if (!in_show) begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            dp_snap_q     <= '0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            digit_idx_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            dp_snap_q     <= dp_snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_idx_q   <= digit_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    logic        clk;
    logic        rst;
    logic [11:0] bcd_in;
    logic [2:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int n_total;
    int n_pass;

    bcd_display_scan #(
        .N            (3),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"}, 32'(an), 32'h7);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    // One cycle where a new snapshot is taken; segment value checked only
    // when the caller knows it (it comes from the previous snapshot).
    task automatic frame_edge(input string tag, input logic [6:0] s, input bit chk_seg);
        cyc();
        check({tag, "_fs"}, 32'(frame_start), 32'h1);
        check({tag, "_an"}, 32'(an), 32'h6);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
        if (chk_seg) check({tag, "_seg"}, 32'(seg), 32'(s));
    endtask

    task automatic show_digit(input string tag, input int d, input logic [6:0] s,
                              input logic p, input int n, input bit guard_after);
        logic [2:0] an_exp;
        an_exp = ~(3'b001 << d);
        for (int k = 0; k < n; k++) begin
            cyc();
            check({tag, "_an"}, 32'(an), 32'(an_exp));
            check({tag, "_seg"}, 32'(seg), 32'(s));
            check({tag, "_dp"}, 32'(dp), 32'(p));
            check({tag, "_idx"}, 32'(digit_idx), 32'(d));
            check({tag, "_fs"}, 32'(frame_start), 32'h0);
        end
`ifdef SCAN_GUARD_EN
        if (guard_after) begin
            for (int g = 0; g < 2; g++) begin
                cyc();
                check({tag, "_g_an"}, 32'(an), 32'h7);
                check({tag, "_g_seg"}, 32'(seg), 32'h7F);
                check({tag, "_g_dp"}, 32'(dp), 32'h1);
                check({tag, "_g_fs"}, 32'(frame_start), 32'h0);
            end
        end
`else
        if (guard_after) check({tag, "_noguard_fs"}, 32'(frame_start), 32'h0);
`endif
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b0;
        bcd_in   = 12'($urandom);
        dp_in    = 3'($urandom);
        blank_lz = 1'b0;

        // Reset held with random inputs
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("t1_rst");

        // Basic scan of 925 with dp on digit 1
        bcd_in = 12'h925;
        dp_in  = 3'b010;
        rst    = 1'b1;
        frame_edge("t2_f0", 7'h00, 1'b0);
        show_digit("t2_d0", 0, 7'h12, 1'b1, 3, 1'b1);
        show_digit("t2_d1", 1, 7'h24, 1'b0, 4, 1'b1);
        show_digit("t2_d2", 2, 7'h10, 1'b1, 4, 1'b1);
        frame_edge("t2_f1", 7'h12, 1'b1);
        show_digit("t2_d0b", 0, 7'h12, 1'b1, 3, 1'b1);

        // Snapshot isolation: change input while digit 1 is shown
        show_digit("t3_d1a", 1, 7'h24, 1'b0, 1, 1'b0);
        bcd_in = 12'h111;
        show_digit("t3_d1b", 1, 7'h24, 1'b0, 3, 1'b1);
        show_digit("t3_d2", 2, 7'h10, 1'b1, 4, 1'b1);
        frame_edge("t3_f", 7'h00, 1'b0);
        show_digit("t3_n0", 0, 7'h79, 1'b1, 3, 1'b1);
        show_digit("t3_n1", 1, 7'h79, 1'b0, 4, 1'b1);
        show_digit("t3_n2", 2, 7'h79, 1'b1, 4, 1'b1);

        // Leading-zero blanking on 007
        blank_lz = 1'b1;
        bcd_in   = 12'h007;
        dp_in    = 3'b000;
        frame_edge("t4_f0", 7'h00, 1'b0);
        show_digit("t4_d0", 0, 7'h78, 1'b1, 3, 1'b1);
        show_digit("t4_d1", 1, 7'h7F, 1'b1, 4, 1'b1);
        show_digit("t4_d2", 2, 7'h7F, 1'b1, 4, 1'b1);

        // All zero: digit 0 still shown
        bcd_in = 12'h000;
        frame_edge("t4_f1", 7'h78, 1'b1);
        show_digit("t4_z0", 0, 7'h40, 1'b1, 3, 1'b1);
        show_digit("t4_z1", 1, 7'h7F, 1'b1, 4, 1'b1);
        show_digit("t4_z2", 2, 7'h7F, 1'b1, 4, 1'b1);

        // Invalid nibble shows a dash
        bcd_in   = 12'h0B3;
        blank_lz = 1'b0;
        frame_edge("t5_f0", 7'h00, 1'b0);
        show_digit("t5_d0", 0, 7'h30, 1'b1, 3, 1'b1);
        show_digit("t5_d1", 1, 7'h3F, 1'b1, 4, 1'b1);
        show_digit("t5_d2", 2, 7'h40, 1'b1, 4, 1'b1);

        // Asynchronous reset between clock edges, mid-scan
        frame_edge("t5_f1", 7'h30, 1'b1);
        show_digit("t5_mid", 0, 7'h30, 1'b1, 1, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset("t5_async");

        // Restart from digit 0 after release
        @(negedge clk);
        bcd_in = 12'h925;
        dp_in  = 3'b010;
        rst    = 1'b1;
        frame_edge("t5_rf", 7'h00, 1'b0);
        show_digit("t5_r0", 0, 7'h12, 1'b1, 3, 1'b1);
        show_digit("t5_r1", 1, 7'h24, 1'b0, 4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
